// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin sharing of one UART transmitter among NUM_REQ byte
//            sources. Optional packet lock via macro ARB_PKT_LOCK_EN.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int BUSY_TO = 16,
    localparam int GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tx_busy,
    output logic                      tx_en,
    output logic [DATA_W-1:0]         tx_data,
    output logic [GID_W-1:0]          grant_id,
    output logic                      arb_busy,
    output logic                      to_err
);

    localparam int               CNT_W    = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TO - 1);
    localparam logic [GID_W-1:0] GID_MAX  = GID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   ptr_q, ptr_d;
    logic [GID_W-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_en_q, tx_en_d;
    logic               to_err_q, to_err_d;
    logic               arb_busy_q, arb_busy_d;

    logic [NUM_REQ-1:0] cand;
    logic               pick_found;
    logic [GID_W-1:0]   pick_idx;
    logic [GID_W-1:0]   scan_idx;
    logic [GID_W-1:0]   pick_next;
    logic [DATA_W-1:0]  pick_data;
    logic               accept;

`ifdef ARB_PKT_LOCK_EN
    logic               lock_q, lock_d;
    logic [GID_W-1:0]   lock_id_q, lock_id_d;

    // While a packet is open only its owner may be granted.
    assign cand = lock_q ? (req_valid & (NUM_REQ'(1) << lock_id_q)) : req_valid;
`else
    logic unused_last;

    assign cand        = req_valid;
    assign unused_last = ^req_last;
`endif

    // First candidate at or after the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = GID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_found && cand[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == GID_W'(i)) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign pick_next = (pick_idx == GID_MAX) ? '0 : pick_idx + 1'b1;
    assign accept    = (state_q == ST_IDLE) && !tx_busy && pick_found;

    // The accept pulse is gated by reset so every output reads 0 while it is held.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && !sys_rst && (pick_idx == GID_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        tx_en_d   = 1'b0;
        to_err_d  = 1'b0;
`ifdef ARB_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_ISSUE;
                    tx_en_d   = 1'b1;
                    tx_data_d = pick_data;
                    grant_d   = pick_idx;
`ifdef ARB_PKT_LOCK_EN
                    if (req_last[pick_idx]) begin
                        lock_d = 1'b0;
                        ptr_d  = pick_next;
                    end else begin
                        lock_d    = 1'b1;
                        lock_id_d = pick_idx;
                    end
`else
                    ptr_d     = pick_next;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    to_err_d = 1'b1;
`ifdef ARB_PKT_LOCK_EN
                    lock_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        arb_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            tx_en_q    <= 1'b0;
            to_err_q   <= 1'b0;
            arb_busy_q <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            tx_en_q    <= tx_en_d;
            to_err_q   <= to_err_d;
            arb_busy_q <= arb_busy_d;
`ifdef ARB_PKT_LOCK_EN
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
`endif
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_q;
    assign arb_busy = arb_busy_q;
    assign to_err   = to_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NREQ  = 4;
    localparam int FRAME = 10;

    logic        clk;
    logic        sys_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_busy;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        to_err;

    // Requester and UART models
    int          budget  [NREQ];
    int          sent    [NREQ];
    int          pkt_len [NREQ];
    logic [7:0]  base    [NREQ];
    logic        clr_sent;
    logic        model_en;
    logic        man_busy;
    logic        model_busy;
    int          busy_left;

    // Grant log
    int          g_log [64];
    int          g_cyc [64];
    int          g_n;
    int          ten_n;
    int          cyc;

    int          n_cmp;
    int          n_err;

    uart_tx_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .BUSY_TO (16)
    ) u_dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_busy   (tx_busy),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy),
        .to_err    (to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = sent[i] < budget[i];
            req_data[i*8 +: 8]   = base[i] + 8'(sent[i]);
            req_last[i]          = (sent[i] % pkt_len[i]) == (pkt_len[i] - 1);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (clr_sent)          sent[i] <= 0;
            else if (req_ready[i]) sent[i] <= sent[i] + 1;
        end
    end

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst)            busy_left <= 0;
        else if (tx_en)         busy_left <= FRAME;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign model_busy = (busy_left > 0);
    assign tx_busy    = model_en ? model_busy : man_busy;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (|req_ready) begin
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_log[g_n] <= i;
            g_cyc[g_n] <= cyc;
            g_n        <= g_n + 1;
        end
        if (tx_en) ten_n <= ten_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drv;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
        #1;
    endtask

    task automatic set_reqs(input int b0, input int b1, input int b2, input int b3);
        drv();
        for (int i = 0; i < NREQ; i++) budget[i] = 0;
        clr_sent = 1'b1;
        drv();
        clr_sent  = 1'b0;
        budget[0] = b0;
        budget[1] = b1;
        budget[2] = b2;
        budget[3] = b3;
    endtask

    task automatic wait_grants(input int target, input int lim, input string tag);
        int c;
        c = 0;
        while (g_n < target && c < lim) begin
            smp();
            c++;
        end
        chk(tag, 32'(g_n >= target), 32'd1);
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int c;
        c = 0;
        while ((arb_busy || tx_busy) && c < lim) begin
            smp();
            c++;
        end
        chk(tag, {31'd0, arb_busy}, 32'd0);
    endtask

    task automatic do_reset;
        drv();
        sys_rst = 1'b1;
        drv();
        drv();
        sys_rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0, te0, acc_cyc;
        int exp_rot [5];
        int exp_pkt [5];
        exp_rot = '{0, 1, 2, 3, 0};
`ifdef ARB_PKT_LOCK_EN
        exp_pkt = '{1, 1, 1, 2, 0};
`else
        exp_pkt = '{1, 2, 0, 1, 1};
`endif
        n_cmp    = 0;
        n_err    = 0;
        g_n      = 0;
        ten_n    = 0;
        cyc      = 0;
        clr_sent = 1'b0;
        model_en = 1'b1;
        man_busy = 1'b0;
        sys_rst  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            budget[i]  = 0;
            pkt_len[i] = 1;
        end
        base[0] = 8'h10;
        base[1] = 8'h20;
        base[2] = 8'hA5;
        base[3] = 8'h40;

        // Reset values
        repeat (3) smp();
        chk("rst_ready",  {28'd0, req_ready}, 32'd0);
        chk("rst_tx_en",  {31'd0, tx_en},     32'd0);
        chk("rst_data",   {24'd0, tx_data},   32'd0);
        chk("rst_gid",    {30'd0, grant_id},  32'd0);
        chk("rst_busy",   {31'd0, arb_busy},  32'd0);
        chk("rst_to_err", {31'd0, to_err},    32'd0);
        drv();
        sys_rst = 1'b0;

        // Single requester 2
        set_reqs(0, 0, 1, 0);
        smp();
        chk("single_ready", {28'd0, req_ready}, 32'h4);
        smp();
        chk("single_tx_en", {31'd0, tx_en},    32'd1);
        chk("single_data",  {24'd0, tx_data},  32'hA5);
        chk("single_gid",   {30'd0, grant_id}, 32'd2);
        chk("single_busy",  {31'd0, arb_busy}, 32'd1);
        wait_idle(40, "single_idle");

        // Continuous rotation from a fresh pointer
        do_reset();
        g0  = g_n;
        te0 = ten_n;
        set_reqs(100, 100, 100, 100);
        wait_grants(g0 + 5, 150, "rot_wait");
        drv();
        for (int i = 0; i < NREQ; i++) budget[i] = 0;
        wait_idle(40, "rot_idle");
        for (int k = 0; k < 5; k++) chk($sformatf("rot_order%0d", k), 32'(g_log[g0+k]), 32'(exp_rot[k]));
        chk("rot_gap",    32'(g_cyc[g0+1] - g_cyc[g0]), 32'd13);
        chk("rot_grants", 32'(g_n - g0),   32'd5);
        chk("rot_tx_en",  32'(ten_n - te0), 32'd5);

        // Reset in the middle of a frame
        g0 = g_n;
        set_reqs(100, 100, 100, 100);
        wait_grants(g0 + 1, 40, "rstmid_wait");
        chk("rstmid_first", 32'(g_log[g0]), 32'd1);
        repeat (5) smp();
        chk("rstmid_busy_pre", {31'd0, arb_busy}, 32'd1);
        @(posedge clk);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("rstmid_busy",  {31'd0, arb_busy},  32'd0);
        chk("rstmid_gid",   {30'd0, grant_id},  32'd0);
        chk("rstmid_data",  {24'd0, tx_data},   32'd0);
        chk("rstmid_ready", {28'd0, req_ready}, 32'd0);
        drv();
        sys_rst = 1'b0;
        g0 = g_n;
        wait_grants(g0 + 1, 20, "rstmid_wait2");
        chk("rstmid_next", 32'(g_log[g0]), 32'd0);
        drv();
        for (int i = 0; i < NREQ; i++) budget[i] = 0;
        wait_idle(40, "rstmid_idle");

        // tx_busy never rises: deadlock guard
        model_en = 1'b0;
        man_busy = 1'b0;
        g0 = g_n;
        set_reqs(0, 0, 0, 1);
        wait_grants(g0 + 1, 20, "to_wait");
        acc_cyc = g_cyc[g0];
        chk("to_gid", 32'(g_log[g0]), 32'd3);
        begin
            int c;
            c = 0;
            while (!to_err && c < 40) begin
                smp();
                c++;
            end
        end
        chk("to_latency", 32'(cyc - acc_cyc), 32'd18);
        chk("to_idle",    {31'd0, arb_busy},  32'd0);
        smp();
        chk("to_pulse",   {31'd0, to_err},    32'd0);

        // tx_busy held high while idle
        drv();
        man_busy = 1'b1;
        g0 = g_n;
        set_reqs(1, 0, 0, 0);
        repeat (5) smp();
        chk("hold_ready", {28'd0, req_ready}, 32'd0);
        chk("hold_none",  32'(g_n - g0),      32'd0);
        drv();
        man_busy = 1'b0;
        smp();
        chk("hold_accept", {28'd0, req_ready}, 32'h1);
        drv();
        model_en = 1'b1;
        wait_idle(40, "hold_idle");

        // Three-byte packet from requester 1 with competitors 0 and 2
        pkt_len[1] = 3;
        g0 = g_n;
        set_reqs(1, 3, 1, 0);
        wait_grants(g0 + 5, 150, "pkt_wait");
        wait_idle(40, "pkt_idle");
        for (int k = 0; k < 5; k++) chk($sformatf("pkt_order%0d", k), 32'(g_log[g0+k]), 32'(exp_pkt[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
